hdb3_tx_sched: RTL

Transmit scheduler for the HDB3 encoder chain. Accepts bytes over a valid/ready handshake and serializes them MSB-first onto the encoder's serial data and enable inputs, so it drives the `data_in`/`en` pair of the V-insertion stage. Each frame is wrapped in an alternating preamble and a zero flush tail, which drains the encoder pipeline. Underruns are filled with zeros, because HDB3 substitution handles zero runs.

---
 rtl/hdb3_tx_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hdb3_tx_sched.sv
// Byte-to-serial scheduler feeding the HDB3 V-insertion stage: alternating preamble,
// MSB-first data with zero fill on underrun, and a zero flush tail per frame.
module hdb3_tx_sched #(
    parameter int PRE_LEN   = 8,
    parameter int FLUSH_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        enc_data,
    output logic        enc_en,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic [15:0] byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_STALL,
        S_FLUSH
    } state_t;

    localparam logic [7:0] PRE_LAST   = 8'(PRE_LEN - 1);
    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        last_q, last_d;
    logic        underrun_q, underrun_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic        done_q, done_d;
    logic        enc_data_q, enc_data_d;
    logic        enc_en_q, enc_en_d;
    logic        hs;

    always_comb begin
        byte_ready = 1'b0;
        case (state_q)
            S_PRE:   byte_ready = (cnt_q == PRE_LAST);
            S_DATA:  byte_ready = (cnt_q == 8'd7) && !last_q;
            S_STALL: byte_ready = 1'b1;
            default: byte_ready = 1'b0;
        endcase
        if (abort) begin
            byte_ready = 1'b0;
        end
    end

    assign hs = byte_valid & byte_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        last_d     = last_q;
        underrun_d = underrun_q;
        byte_cnt_d = byte_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_PRE;
                    cnt_d      = 8'd0;
                    underrun_d = 1'b0;
                    byte_cnt_d = 16'd0;
                end
            end
            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = hs ? S_DATA : S_STALL;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 8'd7) begin
                    cnt_d = 8'd0;
                    if (last_q) begin
                        state_d = S_FLUSH;
                    end else if (hs) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_STALL;
                    end
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    shreg_d = {shreg_q[6:0], 1'b0};
                end
            end
            S_STALL: begin
                if (hs) begin
                    state_d = S_DATA;
                    cnt_d   = 8'd0;
                end
            end
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hs) begin
            shreg_d = byte_data;
            last_d  = byte_last;
            if (byte_cnt_q != 16'hFFFF) begin
                byte_cnt_d = byte_cnt_q + 16'd1;
            end
        end

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end

        // underrun is raised on entry so it is visible alongside the first fill bit
        if (state_d == S_STALL) begin
            underrun_d = 1'b1;
        end

        enc_en_d   = (state_d != S_IDLE);
        enc_data_d = 1'b0;
        case (state_d)
            S_PRE:   enc_data_d = ~cnt_d[0];
            S_DATA:  enc_data_d = shreg_d[7];
            default: enc_data_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            shreg_q    <= 8'd0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
            byte_cnt_q <= 16'd0;
            done_q     <= 1'b0;
            enc_data_q <= 1'b0;
            enc_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_d;
            enc_data_q <= enc_data_d;
            enc_en_q   <= enc_en_d;
        end
    end

    assign enc_data = enc_data_q;
    assign enc_en   = enc_en_q;
    assign busy     = enc_en_q;
    assign done     = done_q;
    assign underrun = underrun_q;
    assign byte_cnt = byte_cnt_q;

endmodule
